// File: rtl/udp_ip_regbank_pkg.sv
// Shared constants, FSM state types and address decode for the UDP/IP AXI4-Lite register bank.
package udp_ip_regbank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_t;

    // Register index from a byte address; the byte-offset bits within a word are dropped.
    function automatic int unsigned reg_index(input logic [31:0] addr, input int unsigned data_width);
        logic [31:0] idx;
        idx = (data_width == 64) ? (addr >> 3) : (addr >> 2);
        return idx;
    endfunction

endpackage

// File: rtl/udp_ip_strb_merge.sv
// Byte-wise merge of new write data into the old register value under the write strobes.
module udp_ip_strb_merge #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   merged_c
);

    // Each strobed byte takes the new data, the rest keep the old value.
    for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
        assign merged_c[b*8 +: 8] = wstrb[b] ? wdata[b*8 +: 8] : old_data[b*8 +: 8];
    end

endmodule

// File: rtl/udp_ip_axil_regbank.sv
// AXI4-Lite control/status register bank for the UDP/IP core.
// NUM_REGS registers of DATA_WIDTH bits; RO_MASK bits select read-only slots fed by status_in.
// Optional macro UDP_IP_REGBANK_ERR_RESP_EN: out-of-range accesses answer SLVERR instead of OKAY.
module udp_ip_axil_regbank
    import udp_ip_regbank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,

    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,

    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,

    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,

    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

`ifdef UDP_IP_REGBANK_ERR_RESP_EN
    localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
    localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

    wstate_t                      w_state, w_next;
    rstate_t                      r_state, r_next;

    logic [NUM_REGS*DATA_WIDTH-1:0] regs_q;
    logic [ADDR_WIDTH-1:0]        aw_addr_q;
    logic [DATA_WIDTH-1:0]        wdata_q;
    logic [STRB_W-1:0]            wstrb_q;

    logic                         aw_hs, w_hs, ar_hs;
    logic                         commit_c;
    logic [ADDR_WIDTH-1:0]        c_addr;
    logic [DATA_WIDTH-1:0]        c_data;
    logic [STRB_W-1:0]            c_strb;
    int unsigned                  c_idx;
    logic                         c_in_range;
    logic [DATA_WIDTH-1:0]        old_c;
    logic [DATA_WIDTH-1:0]        merged_c;
    logic [NUM_REGS-1:0]          wr_pulse_c;

    int unsigned                  r_idx;
    logic                         r_in_range;
    logic [DATA_WIDTH-1:0]        rd_value_c;

    logic                         unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Write FSM next state; commit fires on whichever of AW/W completes the pair.
    always_comb begin
        w_next   = w_state;
        commit_c = 1'b0;
        c_addr   = aw_addr_q;
        c_data   = wdata_q;
        c_strb   = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_c = 1'b1;
                    c_addr   = S_AXI_AWADDR;
                    c_data   = S_AXI_WDATA;
                    c_strb   = S_AXI_WSTRB;
                    w_next   = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_next = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    commit_c = 1'b1;
                    c_data   = S_AXI_WDATA;
                    c_strb   = S_AXI_WSTRB;
                    w_next   = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    commit_c = 1'b1;
                    c_addr   = S_AXI_AWADDR;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Commit target decode: old value for the merge and the per-register write enable.
    always_comb begin
        c_idx      = reg_index(32'(c_addr), DATA_WIDTH);
        c_in_range = (c_idx < NUM_REGS);
        old_c      = '0;
        wr_pulse_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (c_idx == i) begin
                old_c         = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
                wr_pulse_c[i] = commit_c && !RO_MASK[i];
            end
        end
    end

    udp_ip_strb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb_merge (
        .old_data (old_c),
        .wdata    (c_data),
        .wstrb    (c_strb),
        .merged_c (merged_c)
    );

    // Write FSM state, registered readies and write response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            w_state       <= w_next;
            S_AXI_AWREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
            S_AXI_WREADY  <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
            S_AXI_BVALID  <= (w_next == W_RESP);
            if (commit_c) begin
                S_AXI_BRESP <= c_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    // Hold the half of a write that arrives first.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // Register file update and one-cycle write strobes.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q   <= '0;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_pulse_c;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_pulse_c[i]) begin
                    regs_q[i*DATA_WIDTH +: DATA_WIDTH] <= merged_c;
                end
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data source: RW register, status slice for RO, zero when out of range.
    always_comb begin
        r_idx      = reg_index(32'(S_AXI_ARADDR), DATA_WIDTH);
        r_in_range = (r_idx < NUM_REGS);
        rd_value_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == i) begin
                rd_value_c = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH]
                                        : regs_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read FSM state and registered read channel outputs, captured at acceptance.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            r_state       <= r_next;
            S_AXI_ARREADY <= (r_next == R_IDLE);
            S_AXI_RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                S_AXI_RDATA <= rd_value_c;
                S_AXI_RRESP <= r_in_range ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    // Expose RW contents; read-only slots read as zero here.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[g] ? '0 : regs_q[g*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule

// File: tb/tb_udp_ip_axil_regbank.sv
// Self-checking bench for udp_ip_axil_regbank (8 x 32-bit, register 7 read-only).
module tb_udp_ip_axil_regbank;

    localparam logic [7:0] RO_TB = 8'h80;
`ifdef UDP_IP_REGBANK_ERR_RESP_EN
    localparam logic [1:0] OOR_TB = 2'b10;
`else
    localparam logic [1:0] OOR_TB = 2'b00;
`endif

    logic         ACLK;
    logic         ARESET;
    logic [7:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [7:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [255:0] reg_out;
    logic [7:0]   wr_pulse;
    logic [255:0] status_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 0;

    // Behavioural model: register contents plus the update scheduled for the next edge.
    logic [31:0] model_regs [8];
    logic [31:0] next_regs  [8];
    logic [7:0]  next_pulse = '0;
    logic [7:0]  exp_pulse  = '0;
    bit          commit_pending = 0;
    logic        rst_seen;

    udp_ip_axil_regbank #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .NUM_REGS   (8),
        .RO_MASK    (RO_TB)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse),
        .status_in     (status_in)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [255:0] exp_reg_out();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            if (!RO_TB[i]) v[i*32 +: 32] = model_regs[i];
        end
        return v;
    endfunction

    // Schedule the effect of a write whose last handshake happens at the coming edge.
    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, output logic [1:0] resp);
        int unsigned idx;
        idx = 32'(addr) >> 2;
        for (int i = 0; i < 8; i++) next_regs[i] = model_regs[i];
        next_pulse = '0;
        resp = (idx < 8) ? 2'b00 : OOR_TB;
        if (idx < 8 && !RO_TB[idx[2:0]]) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) next_regs[idx[2:0]][b*8 +: 8] = data[b*8 +: 8];
            end
            next_pulse[idx[2:0]] = 1'b1;
        end
        commit_pending = 1;
    endfunction

    function automatic void model_read(input logic [7:0] addr, output logic [31:0] data,
                                       output logic [1:0] resp);
        int unsigned idx;
        idx = 32'(addr) >> 2;
        if (idx >= 8) begin
            data = '0;
            resp = OOR_TB;
        end else begin
            data = RO_TB[idx[2:0]] ? status_in[idx*32 +: 32] : model_regs[idx[2:0]];
            resp = 2'b00;
        end
    endfunction

    // Apply scheduled model updates just after each edge; reset clears everything.
    always @(posedge ACLK) begin
        rst_seen = ARESET;
        #1;
        if (rst_seen) begin
            for (int i = 0; i < 8; i++) model_regs[i] = '0;
            exp_pulse      = '0;
            commit_pending = 0;
        end else if (commit_pending) begin
            for (int i = 0; i < 8; i++) model_regs[i] = next_regs[i];
            exp_pulse      = next_pulse;
            commit_pending = 0;
        end else begin
            exp_pulse = '0;
        end
    end

    // Every cycle: register outputs and write strobes against the model.
    always @(negedge ACLK) begin
        if (check_en) begin
            n_checks++;
            if (reg_out !== exp_reg_out()) begin
                n_fail++;
                $display("FAIL reg_out: got %h expected %h at %0t", reg_out, exp_reg_out(), $time);
            end
            n_checks++;
            if (wr_pulse !== exp_pulse) begin
                n_fail++;
                $display("FAIL wr_pulse: got %h expected %h at %0t", wr_pulse, exp_pulse, $time);
            end
        end
    end

    task automatic start_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, output logic [1:0] exp_resp);
        bit aw_done, w_done, aw_now, w_now;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0; exp_resp = 2'b00;
        S_AXI_AWADDR = addr;
        S_AXI_AWPROT = 3'($urandom_range(0, 7));
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        while (1) begin
            S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
            w_now  = S_AXI_WVALID && S_AXI_WREADY;
            if ((aw_done || aw_now) && (w_done || w_now)) model_write(addr, data, strb, exp_resp);
            @(posedge ACLK);
            aw_done = aw_done || aw_now;
            w_done  = w_done || w_now;
            @(negedge ACLK);
            if (aw_done && w_done) break;
            cyc++;
            if (cyc > 60) begin
                chk("write_handshake_timeout", 64'(0), 64'(1));
                S_AXI_AWVALID = 1'b0;
                S_AXI_WVALID  = 1'b0;
                return;
            end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("b_latency", 64'(S_AXI_BVALID), 64'(1));
        chk("wr_readies_in_resp", 64'({S_AXI_AWREADY, S_AXI_WREADY}), 64'(0));
    endtask

    task automatic finish_write(input int b_dly, input logic [1:0] exp_resp, output logic [1:0] got);
        for (int k = 0; k < b_dly; k++) begin
            chk("bvalid_hold", 64'(S_AXI_BVALID), 64'(1));
            chk("bresp_hold", 64'(S_AXI_BRESP), 64'(exp_resp));
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1'b1;
        chk("bvalid", 64'(S_AXI_BVALID), 64'(1));
        chk("bresp", 64'(S_AXI_BRESP), 64'(exp_resp));
        got = S_AXI_BRESP;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", 64'(S_AXI_BVALID), 64'(0));
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] got);
        logic [1:0] er;
        start_write(addr, data, strb, aw_dly, w_dly, er);
        finish_write(b_dly, er, got);
    endtask

    task automatic start_read(input logic [7:0] addr, input int ar_dly,
                              output logic [31:0] exp_d, output logic [1:0] exp_r);
        bit done;
        int cyc;
        done = 0; cyc = 0; exp_d = '0; exp_r = 2'b00;
        S_AXI_ARADDR = addr;
        S_AXI_ARPROT = 3'($urandom_range(0, 7));
        while (1) begin
            S_AXI_ARVALID = (cyc >= ar_dly);
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                model_read(addr, exp_d, exp_r);
                done = 1;
            end
            @(posedge ACLK);
            @(negedge ACLK);
            if (done) break;
            cyc++;
            if (cyc > 60) begin
                chk("read_handshake_timeout", 64'(0), 64'(1));
                S_AXI_ARVALID = 1'b0;
                return;
            end
        end
        S_AXI_ARVALID = 1'b0;
        chk("r_latency", 64'(S_AXI_RVALID), 64'(1));
        chk("arready_in_data", 64'(S_AXI_ARREADY), 64'(0));
        chk("rdata", 64'(S_AXI_RDATA), 64'(exp_d));
        chk("rresp", 64'(S_AXI_RRESP), 64'(exp_r));
    endtask

    task automatic finish_read(input int r_dly, input logic [31:0] exp_d, input logic [1:0] exp_r,
                               output logic [31:0] got);
        for (int k = 0; k < r_dly; k++) begin
            chk("rvalid_hold", 64'(S_AXI_RVALID), 64'(1));
            chk("rdata_hold", 64'(S_AXI_RDATA), 64'(exp_d));
            chk("rresp_hold", 64'(S_AXI_RRESP), 64'(exp_r));
            @(negedge ACLK);
        end
        got = S_AXI_RDATA;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", 64'(S_AXI_RVALID), 64'(0));
    endtask

    task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] got, output logic [1:0] got_resp);
        logic [31:0] ed;
        logic [1:0]  er;
        start_read(addr, ar_dly, ed, er);
        got_resp = S_AXI_RRESP;
        finish_read(r_dly, ed, er, got);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br, er_w, er_r;
        logic [31:0] ed;
        logic [7:0]  wa, ra;
        logic [31:0] wd;
        logic [3:0]  ws;
        int          op;

        for (int i = 0; i < 8; i++) begin
            model_regs[i] = '0;
            next_regs[i]  = '0;
        end
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
        status_in = '0;

        // Reset values
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check_en = 1;
        chk("rst_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(0));
        chk("rst_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
        chk("rst_resp_data", 64'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 64'(0));
        chk("rst_reg_out", 64'(|reg_out), 64'(0));
        ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("readies_after_reset", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));

        // Basic write/readback of four registers
        for (int i = 0; i < 4; i++) begin
            do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, br);
            chk("basic_bresp", 64'(br), 64'(0));
        end
        for (int i = 0; i < 4; i++) begin
            do_read(8'(i * 4), 0, 0, rd, rr);
            chk("basic_readback", 64'(rd), 64'(i + 1));
            chk("basic_rresp", 64'(rr), 64'(0));
        end

        // Byte-strobe merge
        do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, 1, br);
        do_write(8'h08, 32'h11223344, 4'b0101, 0, 0, 0, br);
        do_read(8'h08, 0, 0, rd, rr);
        chk("strobe_merge", 64'(rd), 64'(32'hAA22CC44));

        // W three cycles ahead of AW, then AW ahead of W
        do_write(8'h14, 32'h0BADCAFE, 4'hF, 3, 0, 0, br);
        do_read(8'h14, 0, 0, rd, rr);
        chk("w_first_commit", 64'(rd), 64'(32'h0BADCAFE));
        do_write(8'h18, 32'h600DF00D, 4'hF, 0, 3, 2, br);
        do_read(8'h18, 0, 0, rd, rr);
        chk("aw_first_commit", 64'(rd), 64'(32'h600DF00D));

        // Read-only register 7
        status_in[7*32 +: 32] = 32'hDEADBEEF;
        do_write(8'h1C, 32'h0, 4'hF, 0, 0, 0, br);
        chk("ro_write_resp", 64'(br), 64'(0));
        do_read(8'h1C, 0, 0, rd, rr);
        chk("ro_read", 64'(rd), 64'(32'hDEADBEEF));

        // Out-of-range index 8
        do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0, br);
        chk("oor_bresp", 64'(br), 64'(OOR_TB));
        do_read(8'h20, 0, 0, rd, rr);
        chk("oor_rdata", 64'(rd), 64'(0));
        chk("oor_rresp", 64'(rr), 64'(OOR_TB));

        // Same-cycle read and write of register 1 returns the old value
        fork
            do_write(8'h04, 32'h00000055, 4'hF, 0, 0, 0, br);
            do_read(8'h04, 0, 0, rd, rr);
        join
        chk("same_cycle_old_value", 64'(rd), 64'(2));
        do_read(8'h05, 0, 0, rd, rr);
        chk("offset_bits_ignored", 64'(rd), 64'(32'h55));

        // Randomised traffic
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 2);
            wa = 8'($urandom_range(0, 47));
            ra = 8'($urandom_range(0, 47));
            wd = $urandom();
            ws = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 8; i++) status_in[i*32 +: 32] = $urandom();
            end
            case (op)
                0: do_write(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3), br);
                1: do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3), rd, rr);
                default: fork
                    do_write(wa, wd, ws, $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 2), br);
                    do_read(ra, $urandom_range(0, 2), $urandom_range(0, 2), rd, rr);
                join
            endcase
        end

        // Reset while both responses are pending
        start_write(8'h0C, 32'h12345678, 4'hF, 0, 0, er_w);
        start_read(8'h0C, 0, ed, er_r);
        for (int k = 0; k < 3; k++) begin
            chk("pending_bvalid", 64'(S_AXI_BVALID), 64'(1));
            chk("pending_rvalid", 64'(S_AXI_RVALID), 64'(1));
            @(negedge ACLK);
        end
        ARESET = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("abort_valids", 64'({S_AXI_BVALID, S_AXI_RVALID}), 64'(0));
        chk("abort_reg_out", 64'(|reg_out), 64'(0));
        ARESET = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("abort_readies", 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 64'(3'b111));
        do_write(8'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, br);
        chk("post_reset_bresp", 64'(br), 64'(0));
        do_read(8'h10, 0, 0, rd, rr);
        chk("post_reset_read", 64'(rd), 64'(32'hCAFEF00D));
        do_read(8'h0C, 0, 0, rd, rr);
        chk("post_reset_cleared", 64'(rd), 64'(0));

        repeat (2) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
